pipelined_add_sub: RTL

PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

---
 rtl/pipelined_add_sub.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipelined_add_sub.sv
// Pipelined add/subtract: the WIDTH-bit carry chain is cut into STAGES slices,
// one slice per stage, with operands and partial sums skewed so words emerge aligned.
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero
);

    localparam int SW = WIDTH / STAGES;

    if (STAGES < 1 || WIDTH < 4 || WIDTH > 64 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_add_sub: WIDTH must be 4..64 and an integer multiple of STAGES");
    end

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic              ovf_q;
    logic              zero_q;

    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_nx;
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic [WIDTH-1:0]  s_nx [STAGES];
    logic [SW:0]       slice;
    logic              msb_cin;
    logic              advance;

    always_comb begin
        advance = !v_q[STAGES-1] || i_ready;
        slice   = '0;

        // Subtraction is folded into the operands at acceptance, so the mode is
        // frozen per transaction and later stages only ever add.
        v_in[0] = i_valid;
        a_in[0] = i_a;
        b_in[0] = i_sub ? ~i_b : i_b;
        s_in[0] = '0;
        c_in[0] = i_carry ^ i_sub;
        for (int unsigned k = 1; k < STAGES; k++) begin
            v_in[k] = v_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
        end

        for (int unsigned k = 0; k < STAGES; k++) begin
            slice = {1'b0, a_in[k][k*SW +: SW]} + {1'b0, b_in[k][k*SW +: SW]}
                  + {{SW{1'b0}}, c_in[k]};
            s_nx[k] = s_in[k];
            s_nx[k][k*SW +: SW] = slice[SW-1:0];
            c_nx[k] = slice[SW];
        end

        // Carry into the MSB recovered from the MSB sum bit and its operand bits.
        msb_cin = s_nx[STAGES-1][WIDTH-1] ^ a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance) begin
            v_q <= v_in;
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (v_in[k]) begin
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                    s_q[k] <= s_nx[k];
                    c_q[k] <= c_nx[k];
                end
            end
            if (v_in[STAGES-1]) begin
                ovf_q  <= msb_cin ^ c_nx[STAGES-1];
                zero_q <= (s_nx[STAGES-1] == '0);
            end
        end
    end

    assign o_ready    = advance;
    assign o_valid    = v_q[STAGES-1];
    assign o_sum      = s_q[STAGES-1];
    assign o_carry    = c_q[STAGES-1];
    assign o_overflow = ovf_q;
    assign o_zero     = zero_q;

endmodule
